// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative tagged branch target buffer
// Valid/tag in flops for combinational update compare; W-stage staging register forwards to lookup.
module btb_assoc #(
  parameter int XLEN      = 64,
  parameter int SETS_LOG2 = 6,
  parameter int WAYS      = 2,
  parameter int TAG_BITS  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallW,
  input  logic            FlushW,
  input  logic [XLEN-1:0] PCF,
  output logic            BTBHitF,
  output logic [XLEN-1:0] BPBTAF,
  output logic [3:0]      BTBIClassF,
  input  logic            UpdateEnM,
  input  logic [XLEN-1:0] PCM,
  input  logic [XLEN-1:0] IEUAdrM,
  input  logic [3:0]      InstrClassM,
  input  logic            InvalidateAll
);

  localparam int SETS = 1 << SETS_LOG2;
  localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [XLEN-1:0]     tgt_q   [SETS][WAYS];
  logic [3:0]          cls_q   [SETS][WAYS];
  logic [WB-1:0]       rr_q    [SETS];

  logic                s_valid_q, s_valid_d;
  logic [XLEN-1:0]     s_pc_q, s_tgt_q;
  logic [3:0]          s_cls_q;

  logic [SETS_LOG2-1:0] f_idx, s_idx;
  logic [TAG_BITS-1:0]  f_tag, s_tag;
  logic                 unused_pc;

  assign f_idx     = PCF[SETS_LOG2:1];
  assign f_tag     = PCF[SETS_LOG2+TAG_BITS:SETS_LOG2+1];
  assign s_idx     = s_pc_q[SETS_LOG2:1];
  assign s_tag     = s_pc_q[SETS_LOG2+TAG_BITS:SETS_LOG2+1];
  assign unused_pc = ^{PCF, PCM, s_pc_q};

  // Lookup: staged update overrides the array, which is read pre-commit.
  logic            arr_hit, fwd_hit;
  logic [XLEN-1:0] arr_tgt;
  logic [3:0]      arr_cls;

  always_comb begin
    arr_hit = 1'b0;
    arr_tgt = '0;
    arr_cls = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[f_idx][w] && tag_q[f_idx][w] == f_tag) begin
        arr_hit = 1'b1;
        arr_tgt = tgt_q[f_idx][w];
        arr_cls = cls_q[f_idx][w];
      end
    end
  end

  assign fwd_hit = s_valid_q && (s_idx == f_idx) && (s_tag == f_tag);

  always_comb begin
    BTBHitF    = 1'b0;
    BPBTAF     = '0;
    BTBIClassF = '0;
    if (reset) begin
      if (fwd_hit) begin
        BTBHitF    = 1'b1;
        BPBTAF     = s_tgt_q;
        BTBIClassF = s_cls_q;
      end else if (arr_hit) begin
        BTBHitF    = 1'b1;
        BPBTAF     = arr_tgt;
        BTBIClassF = arr_cls;
      end
    end
  end

  // Commit way: tag hit, else lowest invalid, else round-robin victim.
  logic          commit, way_hit, inv_found, evict;
  logic [WB-1:0] hit_way, inv_way, vict_way, rr_next;

  always_comb begin
    way_hit   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[s_idx][w] && tag_q[s_idx][w] == s_tag) begin
        way_hit = 1'b1;
        hit_way = WB'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[s_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WB'(w);
      end
    end
  end

  assign commit   = s_valid_q && !StallW && !InvalidateAll;
  assign evict    = !way_hit && !inv_found;
  assign vict_way = way_hit ? hit_way : (inv_found ? inv_way : ((WAYS > 1) ? rr_q[s_idx] : '0));
  assign rr_next  = (WAYS > 1) ? rr_q[s_idx] + 1'b1 : '0;

  always_comb begin
    s_valid_d = s_valid_q;
    if (InvalidateAll)
      s_valid_d = 1'b0;
    else if (!StallW)
      s_valid_d = UpdateEnM && !FlushW;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_valid_q <= 1'b0;
    end else begin
      s_valid_q <= s_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!StallW) begin
      s_pc_q  <= PCM;
      s_tgt_q <= IEUAdrM;
      s_cls_q <= InstrClassM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (InvalidateAll) begin
      for (int s = 0; s < SETS; s++)
        valid_q[s] <= '0;
    end else if (commit) begin
      valid_q[s_idx][vict_way] <= 1'b1;
      if (evict)
        rr_q[s_idx] <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      tag_q[s_idx][vict_way] <= s_tag;
      tgt_q[s_idx][vict_way] <= s_tgt_q;
      cls_q[s_idx][vict_way] <= s_cls_q;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// tb/tb_btb_assoc.sv - directed self-checking bench for btb_assoc
// Set 2 addresses 0x1x04 differ only in tag bits, exercising fill, eviction and forwarding.
module tb_btb_assoc;

  logic        clk;
  logic        reset;
  logic        StallW, FlushW, UpdateEnM, InvalidateAll;
  logic [31:0] PCF, PCM, IEUAdrM, BPBTAF;
  logic [3:0]  InstrClassM, BTBIClassF;
  logic        BTBHitF;

  int errors = 0;
  int checks = 0;

  btb_assoc #(.XLEN(32), .SETS_LOG2(4), .WAYS(2), .TAG_BITS(8)) dut (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
    .PCF(PCF), .BTBHitF(BTBHitF), .BPBTAF(BPBTAF), .BTBIClassF(BTBIClassF),
    .UpdateEnM(UpdateEnM), .PCM(PCM), .IEUAdrM(IEUAdrM),
    .InstrClassM(InstrClassM), .InvalidateAll(InvalidateAll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic [31:0] tgt, input logic [3:0] cls);
    PCF = pc;
    #1;
    check_eq({tag, ".hit"}, {31'd0, BTBHitF}, {31'd0, hit});
    check_eq({tag, ".bta"}, BPBTAF, tgt);
    check_eq({tag, ".cls"}, {28'd0, BTBIClassF}, {28'd0, cls});
  endtask

  task automatic stage(input logic [31:0] pc, input logic [31:0] tgt, input logic [3:0] cls);
    UpdateEnM = 1'b1; PCM = pc; IEUAdrM = tgt; InstrClassM = cls;
    @(posedge clk); #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [3:0] cls);
    stage(pc, tgt, cls);
    UpdateEnM = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; StallW = 1'b0; FlushW = 1'b0; UpdateEnM = 1'b0; InvalidateAll = 1'b0;
    PCF = 32'h8000_0000; PCM = '0; IEUAdrM = '0; InstrClassM = '0;
    repeat (2) @(posedge clk);
    #1;
    look("in_reset", 32'h8000_0000, 1'b0, 32'h0, 4'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    look("reset_miss", 32'h8000_0000, 1'b0, 32'h0, 4'h0);

    PCF = 32'h1004;
    stage(32'h1004, 32'h2000, 4'h1);
    UpdateEnM = 1'b0;
    look("fwd", 32'h1004, 1'b1, 32'h2000, 4'h1);
    @(posedge clk); #1;
    look("array", 32'h1004, 1'b1, 32'h2000, 4'h1);

    upd(32'h1104, 32'h2100, 4'h1);
    upd(32'h1204, 32'h2200, 4'h1);
    look("evict0_a", 32'h1004, 1'b0, 32'h0, 4'h0);
    look("evict0_b", 32'h1104, 1'b1, 32'h2100, 4'h1);
    upd(32'h1304, 32'h2300, 4'h1);
    look("rr_1004", 32'h1004, 1'b0, 32'h0, 4'h0);
    look("rr_1104", 32'h1104, 1'b0, 32'h0, 4'h0);
    look("rr_1204", 32'h1204, 1'b1, 32'h2200, 4'h1);
    look("rr_1304", 32'h1304, 1'b1, 32'h2300, 4'h1);

    upd(32'h1204, 32'h3000, 4'h4);
    look("ovw_1204", 32'h1204, 1'b1, 32'h3000, 4'h4);
    look("ovw_1304", 32'h1304, 1'b1, 32'h2300, 4'h1);
    upd(32'h1504, 32'h2500, 4'h1);
    look("ptr_1204", 32'h1204, 1'b0, 32'h0, 4'h0);
    look("ptr_1304", 32'h1304, 1'b1, 32'h2300, 4'h1);
    look("ptr_1504", 32'h1504, 1'b1, 32'h2500, 4'h1);

    stage(32'h1404, 32'h2400, 4'h1);
    UpdateEnM = 1'b0;
    look("inv_fwd", 32'h1404, 1'b1, 32'h2400, 4'h1);
    InvalidateAll = 1'b1;
    @(posedge clk); #1;
    InvalidateAll = 1'b0;
    look("inv_1404", 32'h1404, 1'b0, 32'h0, 4'h0);
    look("inv_1304", 32'h1304, 1'b0, 32'h0, 4'h0);
    look("inv_1504", 32'h1504, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    look("inv_later", 32'h1404, 1'b0, 32'h0, 4'h0);

    upd(32'h1004, 32'h2000, 4'h1);
    upd(32'h1104, 32'h2100, 4'h1);
    stage(32'h1604, 32'h4600, 4'h2);
    StallW = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    look("stall_1104", 32'h1104, 1'b1, 32'h2100, 4'h1);
    look("stall_fwd", 32'h1604, 1'b1, 32'h4600, 4'h2);
    StallW = 1'b0; UpdateEnM = 1'b0;
    @(posedge clk); #1;
    look("rel_1104", 32'h1104, 1'b0, 32'h0, 4'h0);
    look("rel_1004", 32'h1004, 1'b1, 32'h2000, 4'h1);
    look("rel_1604", 32'h1604, 1'b1, 32'h4600, 4'h2);

    FlushW = 1'b1;
    stage(32'h1804, 32'h5000, 4'h1);
    FlushW = 1'b0; UpdateEnM = 1'b0;
    look("flush_fwd", 32'h1804, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    look("flush_arr", 32'h1804, 1'b0, 32'h0, 4'h0);
    look("flush_1004", 32'h1004, 1'b1, 32'h2000, 4'h1);

    stage(32'h1a04, 32'h5a00, 4'h1);
    StallW = 1'b1; InvalidateAll = 1'b1; UpdateEnM = 1'b0;
    @(posedge clk); #1;
    InvalidateAll = 1'b0;
    look("invst_fwd", 32'h1a04, 1'b0, 32'h0, 4'h0);
    StallW = 1'b0;
    @(posedge clk); #1;
    look("invst_arr", 32'h1a04, 1'b0, 32'h0, 4'h0);
    look("invst_1004", 32'h1004, 1'b0, 32'h0, 4'h0);

    stage(32'h1c04, 32'h6000, 4'h8);
    StallW = 1'b1; UpdateEnM = 1'b0;
    look("rst_fwd", 32'h1c04, 1'b1, 32'h6000, 4'h8);
    reset = 1'b0;
    look("rst_mid", 32'h1c04, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    reset = 1'b1; StallW = 1'b0;
    @(posedge clk); #1;
    look("rst_after", 32'h1c04, 1'b0, 32'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
